// File: rtl/memif_apb.sv
// Bridges a single-cycle memory request port onto an APB master (SETUP/ACCESS),
// returning a one-cycle completion pulse with registered read data and error flag.
module memif_apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    mreq_i,
  input  logic [ADDR_WIDTH-1:0]   maddr_i,
  input  logic                    mwe_i,
  input  logic [DATA_WIDTH-1:0]   mwdata_i,
  input  logic [DATA_WIDTH/8-1:0] mstrb_i,
  output logic                    mack_o,
  output logic [DATA_WIDTH-1:0]   mrdata_o,
  output logic                    mresp_o,
  output logic                    busy_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  output logic [1:0]              state_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;

  // The counter only ever reaches TIMEOUT_CYCLES-1 before the FSM leaves ACCESS.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES > 0) begin
      timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
      mack_o   <= 1'b0;
      mrdata_o <= '0;
      mresp_o  <= 1'b0;
    end else begin
      mack_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mreq_i) begin
            paddr_o  <= maddr_i;
            pwrite_o <= mwe_i;
            pwdata_o <= mwdata_i;
            pstrb_o  <= mwe_i ? mstrb_i : {STRB_W{1'b0}};
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_q   <= '0;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            mack_o   <= 1'b1;
            mresp_o  <= pslverr_i;
            mrdata_o <= pwrite_o ? {DATA_WIDTH{1'b0}} : prdata_i;
            state_q  <= ST_IDLE;
          end else if (timeout_hit) begin
            mack_o   <= 1'b1;
            mresp_o  <= 1'b1;
            mrdata_o <= '0;
            state_q  <= ST_IDLE;
          end else if (TIMEOUT_CYCLES > 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign psel_o    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable_o = (state_q == ST_ACCESS);
  assign busy_o    = psel_o;
  assign state_o   = state_q;

endmodule

// File: tb/tb_memif_apb.sv
// Directed bench for memif_apb: cycle-accurate APB sequencing, wait states,
// slave error, timeout, request dropping/back-to-back and mid-transfer reset.
module tb_memif_apb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          mreq_i = 1'b0;
  logic [AW-1:0] maddr_i = '0;
  logic          mwe_i = 1'b0;
  logic [DW-1:0] mwdata_i = '0;
  logic [3:0]    mstrb_i = '0;
  logic          mack_o;
  logic [DW-1:0] mrdata_o;
  logic          mresp_o;
  logic          busy_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [3:0]    pstrb_o;
  logic          pready_i = 1'b0;
  logic          pslverr_i = 1'b0;
  logic [DW-1:0] prdata_i = '0;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  memif_apb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni), .mreq_i(mreq_i), .maddr_i(maddr_i),
    .mwe_i(mwe_i), .mwdata_i(mwdata_i), .mstrb_i(mstrb_i), .mack_o(mack_o),
    .mrdata_o(mrdata_o), .mresp_o(mresp_o), .busy_o(busy_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .prdata_i(prdata_i), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {psel_o, penable_o, pwrite_o, mack_o, mresp_o, busy_o, state_o}, '0);
    check({tag, "_paddr"}, paddr_o, '0);
    check({tag, "_pwdata"}, pwdata_o, '0);
    check({tag, "_pstrb"}, pstrb_o, '0);
    check({tag, "_mrdata"}, mrdata_o, '0);
  endtask

  // Drives one request from the current cycle and checks every cycle through the
  // completion pulse; returns positioned in the mack_o cycle.
  task automatic xfer(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd,
                      input logic [3:0] st, input int waits, input logic err,
                      input logic [DW-1:0] rd, input logic tmo, input logic poke);
    logic [3:0] exp_strb;
    exp_strb = we ? st : 4'h0;
    exp_q.push_back((we || tmo) ? '0 : rd);
    mreq_i = 1'b1; maddr_i = addr; mwe_i = we; mwdata_i = wd; mstrb_i = st;
    pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'hBAD0_BAD0;
    step();
    mreq_i = 1'b0;
    check("setup_state", state_o, S_SETUP);
    check("setup_pins", {psel_o, penable_o, busy_o, mack_o}, 4'b1010);
    for (int i = 0; i <= waits; i++) begin
      step();
      check("acc_state", state_o, S_ACCESS);
      check("acc_pins", {psel_o, penable_o, busy_o, mack_o}, 4'b1110);
      check("acc_paddr", paddr_o, addr);
      check("acc_pwrite", pwrite_o, we);
      check("acc_pwdata", pwdata_o, wd);
      check("acc_pstrb", pstrb_o, exp_strb);
      if (poke && i == 0) begin
        mreq_i = 1'b1; maddr_i = 32'h0000_0FF0; mwe_i = ~we; mwdata_i = 32'h1234_5678;
      end else begin
        mreq_i = 1'b0;
      end
      pready_i  = (i == waits) && !tmo;
      pslverr_i = err;
      prdata_i  = rd;
    end
    step();
    mreq_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h5555_AAAA;
    check("ack_pulse", mack_o, 1'b1);
    check("ack_resp", mresp_o, tmo ? 1'b1 : err);
    check("ack_rdata", mrdata_o, exp_q.pop_front());
    check("ack_idle", {state_o, psel_o, penable_o, busy_o}, {S_IDLE, 3'b000});
    check("ack_paddr_hold", paddr_o, addr);
    check("ack_pstrb_hold", pstrb_o, exp_strb);
  endtask

  initial begin
    logic [DW-1:0] last_rd;
    #2;
    check_all_zero("reset");
    step();
    arst_ni = 1'b1;
    step();
    check_all_zero("post_reset_idle");

    // Write, immediate ready: SETUP N+1, ACCESS N+2, ack N+3
    xfer(32'h10, 1'b1, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    check("ack_one_cycle", mack_o, 1'b0);
    check("write_rdata_hold", mrdata_o, 32'h0);

    // Read, three wait states (ready lands on the timeout cycle and wins): ack N+6
    xfer(32'h20, 1'b0, 32'h0, 4'hF, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step();
    check("read_rdata_hold", mrdata_o, 32'hDEAD_BEEF);
    check("read_resp_hold", mresp_o, 1'b0);

    // Read with slave error
    xfer(32'h24, 1'b0, 32'h0, 4'h3, 1, 1'b1, 32'hCAFE_0042, 1'b0, 1'b0);
    step();
    check("err_resp_hold", mresp_o, 1'b1);

    // Timeout: ready never comes, exactly 4 ACCESS cycles
    xfer(32'h30, 1'b0, 32'h0, 4'h0, 3, 1'b0, 32'h7777_7777, 1'b1, 1'b0);
    step();
    check("tmo_after_idle", {mack_o, busy_o, state_o}, {2'b00, S_IDLE});

    // Request pulsed in ACCESS is dropped, not queued
    xfer(32'h40, 1'b1, 32'h0BAD_F00D, 4'h5, 1, 1'b0, 32'h0, 1'b0, 1'b1);
    step();
    check("dropped_no_setup", state_o, S_IDLE);
    step();
    check("dropped_no_ack", {mack_o, busy_o}, 2'b00);

    // Request in the ack cycle is accepted (back-to-back)
    last_rd = 32'h0102_0304;
    xfer(32'h50, 1'b0, 32'h0, 4'h0, 0, 1'b0, last_rd, 1'b0, 1'b0);
    xfer(32'h54, 1'b1, 32'hFEED_FACE, 4'h9, 2, 1'b0, 32'h0, 1'b0, 1'b0);
    step();

    // Reset mid-ACCESS aborts without ack
    mreq_i = 1'b1; maddr_i = 32'h60; mwe_i = 1'b1; mwdata_i = 32'hAAAA_5555; mstrb_i = 4'hF;
    step();
    mreq_i = 1'b0;
    step();
    check("pre_rst_access", state_o, S_ACCESS);
    arst_ni = 1'b0;
    #1;
    check_all_zero("rst_mid_access");
    pready_i = 1'b1;
    step();
    check_all_zero("rst_held");
    pready_i = 1'b0;
    #2 arst_ni = 1'b1;
    step();
    check("rst_no_ack", {mack_o, busy_o, state_o}, {2'b00, S_IDLE});
    xfer(32'h70, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h1357_9BDF, 1'b0, 1'b0);
    step();
    check("final_ack_low", mack_o, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memif_apb.md
MEMIF_APB -- requirements
Module: memif_apb

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data bus width (multiple of 8).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum ACCESS cycles before forced error; 0 disables the timeout.
REQ-004 The block SHALL have port clk_i, input, 1, clock.
REQ-005 The block SHALL have port arst_ni, input, 1, reset (asynchronous, active-low).
REQ-006 The block SHALL have port mreq_i, input, 1, single-cycle memory request.
REQ-007 The block SHALL have port maddr_i, input, ADDR_WIDTH, request address.
REQ-008 The block SHALL have port mwe_i, input, 1, write enable (1 = write).
REQ-009 The block SHALL have port mwdata_i, input, DATA_WIDTH, write data.
REQ-010 The block SHALL have port mstrb_i, input, DATA_WIDTH/8, byte strobe.
REQ-011 The block SHALL have port mack_o, output, 1, completion pulse.
REQ-012 The block SHALL have port mrdata_o, output, DATA_WIDTH, read data.
REQ-013 The block SHALL have port mresp_o, output, 1, error response.
REQ-014 The block SHALL have port busy_o, output, 1, transfer in progress.
REQ-015 The block SHALL have APB master ports psel_o, penable_o, pwrite_o (output, 1 each), paddr_o (output, ADDR_WIDTH), pwdata_o (output, DATA_WIDTH) and pstrb_o (output, DATA_WIDTH/8).
REQ-016 The block SHALL have APB master inputs pready_i and pslverr_i (input, 1 each) and prdata_i (input, DATA_WIDTH).

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP and ACCESS.
REQ-018 In IDLE, mreq_i=1 SHALL register maddr_i, mwe_i, mwdata_i and mstrb_i, then move to SETUP on the next edge.
REQ-019 SETUP SHALL drive psel_o=1 and penable_o=0 for exactly one cycle, then move to ACCESS.
REQ-020 ACCESS SHALL drive psel_o=1 and penable_o=1, and hold every APB output stable until exit.
REQ-021 In ACCESS, pready_i=1 SHALL move the FSM to IDLE and register mack_o=1 for exactly one cycle.
REQ-022 With the completion pulse, mresp_o SHALL take pslverr_i, and mrdata_o SHALL take prdata_i for reads or all-zero for writes.
REQ-023 mrdata_o and mresp_o SHALL hold their values until the next completion.
REQ-024 Minimum latency SHALL be: mreq_i at cycle N, SETUP at N+1, ACCESS at N+2, mack_o at N+3 (pready_i=1 at N+2).
REQ-025 paddr_o, pwrite_o and pwdata_o SHALL be the captured values.
REQ-026 pstrb_o SHALL be the captured strobe on writes and all-zero on reads.
REQ-027 In IDLE, psel_o and penable_o SHALL be 0; paddr_o, pwrite_o, pwdata_o and pstrb_o SHALL hold their last values.
REQ-028 busy_o SHALL be 1 in SETUP and ACCESS and 0 in IDLE.
REQ-029 mreq_i SHALL be ignored when the FSM is not in IDLE, with no queueing and no ack for the dropped request.
REQ-030 mreq_i in the same cycle as mack_o=1 (FSM already in IDLE) SHALL be accepted.
REQ-031 With TIMEOUT_CYCLES>0, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle with pready_i=0.
REQ-032 When the counter reaches TIMEOUT_CYCLES-1 with pready_i=0, the block SHALL go to IDLE and complete with mack_o=1, mresp_o=1 and mrdata_o all-zero.
REQ-033 pready_i=1 in the timeout cycle SHALL win and complete normally.
REQ-034 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), with no wrap-around reachable.
REQ-035 pready_i, pslverr_i and prdata_i SHALL be ignored outside ACCESS.

Reset
REQ-036 While arst_ni=0, the block SHALL force state IDLE, counter 0, and all outputs to zero (psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, mack_o, mrdata_o, mresp_o, busy_o).
REQ-037 Reset asserted mid-transfer SHALL abort the transfer with no mack_o, and the first post-reset mreq_i SHALL be accepted normally.

Verification
REQ-038 The bench SHALL cover: write maddr=0x10, mwdata=0xA5A5_0001, mstrb=0xF, slave pready=1 immediately -> SETUP at N+1, ACCESS at N+2, mack_o at N+3, mresp_o=0, mrdata_o=0.
REQ-039 The bench SHALL cover: read 0x20, slave 3 wait states, prdata=0xDEAD_BEEF -> pstrb_o=0, APB outputs stable in ACCESS, mack_o at N+6, mrdata_o=0xDEAD_BEEF.
REQ-040 The bench SHALL cover: read with pslverr_i=1 at completion -> mack_o=1, mresp_o=1.
REQ-041 The bench SHALL cover: TIMEOUT_CYCLES=4, pready_i held 0 -> exactly 4 ACCESS cycles, then mack_o=1, mresp_o=1, mrdata_o=0, busy_o=0.
REQ-042 The bench SHALL cover: mreq_i pulsed during ACCESS -> ignored; mreq_i during the mack_o cycle -> SETUP on the next cycle.
REQ-043 The bench SHALL cover: arst_ni pulsed low in ACCESS -> all outputs 0 immediately, no mack_o; next request completes normally.
